// File: rtl/systolic_seq_if.sv
// Host-side control bundle of the systolic-array sequencer: start/busy/done,
// the load handshake with its memory strobes, array enables and C readout.
interface systolic_seq_if #(
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM),
  parameter int CNTBITS = $clog2(3*DIM)
);
  logic               start;
  logic               busy;
  logic               done;
  logic               ld_valid;
  logic               ld_ready;
  logic [ROWBITS-1:0] ld_row;
  logic               memA_WrEn;
  logic               memB_WrEn;
  logic               mem_en;
  logic               sa_en;
  logic               sa_clr;
  logic               c_valid;
  logic               c_ready;
  logic [ROWBITS-1:0] sa_Crow;
  logic [CNTBITS-1:0] cyc_cnt;

  // host side
  modport master (
    output start, ld_valid, c_ready,
    input  busy, done, ld_ready, ld_row, memA_WrEn, memB_WrEn,
           mem_en, sa_en, sa_clr, c_valid, sa_Crow, cyc_cnt
  );

  // sequencer side
  modport slave (
    input  start, ld_valid, c_ready,
    output busy, done, ld_ready, ld_row, memA_WrEn, memB_WrEn,
           mem_en, sa_en, sa_clr, c_valid, sa_Crow, cyc_cnt
  );
endinterface

// File: rtl/systolic_seq.sv
// Control sequencer for one DIMxDIM systolic matrix-multiply pass:
// clear accumulators, load A rows, load B rows, run the fill/compute/drain
// window of 3*DIM-2 cycles, then hand C rows to the host.
module systolic_seq #(
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM),
  parameter int CNTBITS = $clog2(3*DIM)
) (
  input  logic          clk,
  input  logic          rst,
  systolic_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ROWBITS-1:0] ROW_LAST = ROWBITS'(DIM-1);
  localparam logic [CNTBITS-1:0] CYC_LAST = CNTBITS'(3*DIM-3);

  state_t             r_state, w_nxt;
  logic [ROWBITS-1:0] r_row;
  logic [CNTBITS-1:0] r_cnt;

  logic w_load, w_beat, w_row_last, w_c_hs;

  assign w_load     = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_beat     = w_load && bus.ld_valid;
  assign w_row_last = (r_row == ROW_LAST);
  assign w_c_hs     = (r_state == S_DRAIN) && bus.c_ready;

  // state register; reset abandons any pass in flight
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // row counter shared by load and drain; cycle counter for the compute window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_CLEAR: r_row <= '0;
        S_LOAD_A, S_LOAD_B: begin
          if (w_beat) r_row <= w_row_last ? '0 : r_row + 1'b1;
          if (w_beat && w_row_last && (r_state == S_LOAD_B)) r_cnt <= '0;
        end
        // last compute cycle holds the count so it stays visible afterwards
        S_COMPUTE: if (r_cnt != CYC_LAST) r_cnt <= r_cnt + 1'b1;
        S_DRAIN:   if (w_c_hs) r_row <= w_row_last ? '0 : r_row + 1'b1;
        default: ;
      endcase
    end
  end

  // next state and control outputs decoded from the current state
  always_comb begin
    w_nxt         = r_state;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = 1'b0;
    bus.sa_clr    = 1'b0;
    bus.ld_ready  = w_load;
    bus.ld_row    = '0;
    bus.memA_WrEn = 1'b0;
    bus.memB_WrEn = 1'b0;
    bus.mem_en    = 1'b0;
    bus.sa_en     = 1'b0;
    bus.c_valid   = 1'b0;
    bus.sa_Crow   = '0;
    case (r_state)
      S_IDLE:  if (bus.start) w_nxt = S_CLEAR;
      S_CLEAR: begin
        bus.sa_clr = 1'b1;
        w_nxt      = S_LOAD_A;
      end
      S_LOAD_A: begin
        bus.ld_row    = r_row;
        bus.memA_WrEn = w_beat;
        if (w_beat && w_row_last) w_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.ld_row    = r_row;
        bus.memB_WrEn = w_beat;
        if (w_beat && w_row_last) w_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        bus.mem_en = 1'b1;
        bus.sa_en  = 1'b1;
        if (r_cnt == CYC_LAST) w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.c_valid = 1'b1;
        bus.sa_Crow = r_row;
        if (w_c_hs && w_row_last) w_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_nxt    = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign bus.cyc_cnt = r_cnt;
endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: per-pass expected traces are built phase by phase
// from the pass rules (load beats, fixed compute window, drain handshakes)
// and compared cycle by cycle against the sequencer outputs.
module tb_systolic_seq;
  localparam int DIM = 8;
  localparam int RB  = $clog2(DIM);
  localparam int CB  = $clog2(3*DIM);
  localparam int VW  = 6 + RB + 2 + CB + 1 + RB;
  localparam int ND  = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_seq_if #(.DIM(DIM)) sif();
  systolic_seq #(.DIM(DIM)) dut (.clk(clk), .rst(rst), .bus(sif));

  int checks = 0;
  int errors = 0;

  bit            lpat [64];
  bit            dpat [64];
  bit            strt [ND];
  logic [VW-1:0] expv [ND];
  logic [VW-1:0] obsv [ND];
  int rst_at, last_cnt, E, T, dstart, nstrobe, ndone;

  function automatic logic [VW-1:0] pk(bit busy, bit done, bit clr, bit rdy,
      bit wa, bit wb, int row, bit men, bit saen, int cnt, bit cv, int crow);
    return {busy, done, clr, rdy, wa, wb, RB'(row), men, saen, CB'(cnt),
            cv, RB'(crow)};
  endfunction

  function automatic logic [VW-1:0] observe();
    return {sif.busy, sif.done, sif.sa_clr, sif.ld_ready, sif.memA_WrEn,
            sif.memB_WrEn, sif.ld_row, sif.mem_en, sif.sa_en, sif.cyc_cnt,
            sif.c_valid, sif.sa_Crow};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin lpat[i] = 1'b1; dpat[i] = 1'b1; end
    for (int i = 0; i < ND; i++) strt[i] = 1'b0;
    rst_at = -1;
  endtask

  // Expected trace, t=0 is the CLEAR cycle: loads finish after 2*DIM beats,
  // compute lasts 3*DIM-2 cycles, drain after DIM handshakes, then one DONE.
  task automatic build_exp();
    int t, b, r;
    bit v;
    for (int i = 0; i < ND; i++) expv[i] = '0;
    expv[0] = pk(1,0,1,0,0,0,0,0,0,last_cnt,0,0);
    t = 1; b = 0;
    while (b < 2*DIM) begin
      v = lpat[t-1];
      expv[t] = pk(1,0,0,1, v && b < DIM, v && b >= DIM, b % DIM, 0,0,
                   last_cnt, 0,0);
      if (v) b++;
      t++;
    end
    for (int i = 0; i < 3*DIM-2; i++) begin
      expv[t] = pk(1,0,0,0,0,0,0,1,1,i,0,0);
      t++;
    end
    last_cnt = 3*DIM-3;
    dstart = t; r = 0;
    while (r < DIM) begin
      expv[t] = pk(1,0,0,0,0,0,0,0,0,last_cnt,1,r);
      if (dpat[t-dstart]) r++;
      t++;
    end
    expv[t]   = pk(1,1,0,0,0,0,0,0,0,last_cnt,0,0);
    E         = t + 1;
    expv[E]   = pk(0,0,0,0,0,0,0,0,0,last_cnt,0,0);
    expv[E+1] = expv[E];
    T = E + 2;
    if (rst_at >= 0) begin
      for (int i = rst_at + 1; i < rst_at + 4; i++) expv[i] = '0;
      T = rst_at + 4;
      last_cnt = 0;
    end
  endtask

  // one pulse of start, then T cycles of stimulus and sampling
  task automatic run_pass();
    int t;
    nstrobe = 0; ndone = 0;
    @(negedge clk);
    rst = 1'b0; sif.start = 1'b1;
    @(negedge clk);
    for (t = 0; t < T; t++) begin
      sif.start    = strt[t];
      rst          = (t == rst_at);
      sif.ld_valid = (t >= 1 && t - 1 < 64) ? lpat[t-1] : 1'($urandom % 2);
      sif.c_ready  = (t >= dstart && t - dstart < 64) ? dpat[t-dstart]
                                                      : 1'($urandom % 2);
      #1;
      obsv[t] = observe();
      nstrobe += int'(sif.memA_WrEn) + int'(sif.memB_WrEn);
      ndone   += int'(sif.done);
      @(negedge clk);
    end
    sif.start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sif.start = 1'b0; sif.ld_valid = 1'b0; sif.c_ready = 1'b0;
    last_cnt = 0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (observe() !== '0) begin
      errors++; $display("FAIL reset_hold got %h exp 0", observe());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (observe() !== '0) begin
        errors++; $display("FAIL reset_idle cyc=%0d got %h exp 0", i, observe());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_pass();
    int dpos;
    clear_stim(); build_exp(); run_pass();
    dpos = -1;
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL full_pass t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
      if (obsv[t][VW-2] === 1'b1 && dpos < 0) dpos = t;
    end
    checks++;
    if (dpos !== 6*DIM - 1) begin
      errors++; $display("FAIL full_latency done_at=%0d exp %0d", dpos, 6*DIM-1);
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL full_done_count got %0d exp 1", ndone);
    end
  endtask

  task automatic test_load_backpressure();
    clear_stim();
    for (int i = 0; i < 64; i++) lpat[i] = (i % 3 == 0);
    build_exp(); run_pass();
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL load_bp t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
    end
    checks++;
    if (nstrobe !== 2*DIM) begin
      errors++; $display("FAIL load_bp_strobes got %0d exp %0d", nstrobe, 2*DIM);
    end
  endtask

  task automatic test_drain_backpressure();
    clear_stim();
    for (int i = 4; i < 7; i++) dpat[i] = 1'b0;
    build_exp(); run_pass();
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL drain_bp t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_stim(); build_exp();
    strt[1 + DIM + 2] = 1'b1;
    strt[E-1] = 1'b1;
    run_pass();
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL start_ign t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL start_ign_done got %0d exp 1", ndone);
    end
  endtask

  task automatic test_mid_reset();
    int ld;
    clear_stim();
    rst_at = 1 + 2*DIM + 10;
    build_exp(); run_pass();
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL mid_reset t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
    end
    clear_stim(); build_exp(); run_pass();
    for (int t = 0; t < T; t++) begin
      checks++;
      if (obsv[t] !== expv[t]) begin
        errors++; $display("FAIL post_reset t=%0d got %h exp %h", t, obsv[t], expv[t]);
      end
    end
    ld = ndone;
    checks++;
    if (ld !== 1) begin
      errors++; $display("FAIL post_reset_done got %0d exp 1", ld);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      clear_stim();
      for (int i = 0; i < 40; i++) lpat[i] = 1'($urandom % 2);
      for (int i = 0; i < 24; i++) dpat[i] = 1'($urandom % 2);
      build_exp();
      for (int i = 0; i < E; i++) strt[i] = ($urandom % 4 == 0);
      run_pass();
      for (int t = 0; t < T; t++) begin
        checks++;
        if (obsv[t] !== expv[t]) begin
          errors++; $display("FAIL random p=%0d t=%0d got %h exp %h", p, t, obsv[t], expv[t]);
        end
      end
      checks++;
      if (nstrobe !== 2*DIM) begin
        errors++; $display("FAIL random_strobes p=%0d got %0d exp %0d", p, nstrobe, 2*DIM);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_load_backpressure();
    test_drain_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
